// File: rtl/step_trace_uart.sv
// Trace transmitter: on each rising step edge, snapshots the CPU debug state and
// sends "CC PPP Rrr=DDDDDDDD\r\n" over an 8N1 UART. Edges that arrive mid-line are dropped and flagged.
module step_trace_uart #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        step,
  input  logic [7:0]  step_count,
  input  logic [8:0]  pc,
  input  logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic        tx,
  output logic        busy,
  output logic        dropped
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    LAST_CHAR  = 5'd20;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state;
  logic           step_q;
  logic [TW-1:0]  timer;
  logic [2:0]     bit_idx;
  logic [4:0]     char_idx;
  logic [7:0]     snap_count;
  logic [8:0]     snap_pc;
  logic [4:0]     snap_sel;
  logic [31:0]    snap_data;
  logic [7:0]     cur_char;
  logic [2:0]     next_bit;
  logic           step_edge;

  assign step_edge = step & ~step_q;
  assign next_bit  = bit_idx + 3'd1;

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    cur_char = 8'h0A;
    case (char_idx)
      5'd0:    cur_char = hex_ch(snap_count[7:4]);
      5'd1:    cur_char = hex_ch(snap_count[3:0]);
      5'd2:    cur_char = 8'h20;
      5'd3:    cur_char = hex_ch({3'b000, snap_pc[8]});
      5'd4:    cur_char = hex_ch(snap_pc[7:4]);
      5'd5:    cur_char = hex_ch(snap_pc[3:0]);
      5'd6:    cur_char = 8'h20;
      5'd7:    cur_char = 8'h52;
      5'd8:    cur_char = hex_ch({3'b000, snap_sel[4]});
      5'd9:    cur_char = hex_ch(snap_sel[3:0]);
      5'd10:   cur_char = 8'h3D;
      5'd11:   cur_char = hex_ch(snap_data[31:28]);
      5'd12:   cur_char = hex_ch(snap_data[27:24]);
      5'd13:   cur_char = hex_ch(snap_data[23:20]);
      5'd14:   cur_char = hex_ch(snap_data[19:16]);
      5'd15:   cur_char = hex_ch(snap_data[15:12]);
      5'd16:   cur_char = hex_ch(snap_data[11:8]);
      5'd17:   cur_char = hex_ch(snap_data[7:4]);
      5'd18:   cur_char = hex_ch(snap_data[3:0]);
      5'd19:   cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      step_q     <= 1'b1;
      tx         <= 1'b1;
      busy       <= 1'b0;
      dropped    <= 1'b0;
      timer      <= '0;
      bit_idx    <= 3'd0;
      char_idx   <= 5'd0;
      snap_count <= 8'd0;
      snap_pc    <= 9'd0;
      snap_sel   <= 5'd0;
      snap_data  <= 32'd0;
    end else begin
      step_q <= step;
      if (step_edge && state != IDLE)
        dropped <= 1'b1;

      case (state)
        IDLE: begin
          if (step_edge) begin
            snap_count <= step_count;
            snap_pc    <= pc;
            snap_sel   <= reg_sel;
            snap_data  <= reg_data;
            char_idx   <= 5'd0;
            timer      <= TIMER_LOAD;
            tx         <= 1'b0;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (timer == '0) begin
            timer   <= TIMER_LOAD;
            bit_idx <= 3'd0;
            tx      <= cur_char[0];
            state   <= DATA;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DATA: begin
          if (timer == '0) begin
            timer <= TIMER_LOAD;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= next_bit;
              tx      <= cur_char[next_bit];
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        STOP: begin
          if (timer == '0) begin
            char_idx <= char_idx + 5'd1;
            if (char_idx < LAST_CHAR) begin
              // next start bit follows the stop bit with no idle gap
              timer <= TIMER_LOAD;
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_trace_uart.sv
// Directed bench for step_trace_uart at 4 clocks per bit: decodes lines at mid-bit and
// compares against hand-written expected characters and cycle counts.
module tb_step_trace_uart;

  localparam int CPB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        step = 1'b1;
  logic [7:0]  step_count = 8'd0;
  logic [8:0]  pc = 9'd0;
  logic [4:0]  reg_sel = 5'd0;
  logic [31:0] reg_data = 32'd0;
  logic        tx, busy, dropped;

  int checks = 0;
  int errors = 0;

  int busy_cnt = 0;
  int tx_low_cnt = 0;

  logic [7:0] rx [21];
  int         waits [21];
  int         frame_err;
  int         timed_out;

  step_trace_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .step(step), .step_count(step_count),
    .pc(pc), .reg_sel(reg_sel), .reg_data(reg_data),
    .tx(tx), .busy(busy), .dropped(dropped)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (busy === 1'b1) busy_cnt++;
    if (tx === 1'b0) tx_low_cnt++;
  end

  // Sample-only UART receiver: finds each start bit, then samples at mid-bit.
  task automatic recv_line(input int first_limit);
    int n;
    logic [7:0] b;
    timed_out = 0;
    frame_err = 0;
    for (int c = 0; c < 21; c++) begin
      rx[c] = 8'h00;
      waits[c] = 0;
    end
    for (int c = 0; c < 21; c++) begin
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (tx !== 1'b0 && n < ((c == 0) ? first_limit : 100));
      if (tx !== 1'b0) begin
        timed_out = 1;
        return;
      end
      waits[c] = n;
      repeat (CPB/2) @(negedge clock);
      if (tx !== 1'b0) frame_err++;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clock);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clock);
      if (tx !== 1'b1) frame_err++;
      rx[c] = b;
    end
  endtask

  task automatic fire_step(input logic [7:0] sc, input logic [8:0] p,
                           input logic [4:0] rs, input logic [31:0] d);
    @(negedge clock);
    step = 1'b0;
    @(negedge clock);
    step_count = sc; pc = p; reg_sel = rs; reg_data = d;
    step = 1'b1;
  endtask

  task automatic test_reset;
    int tb0, bb0;
    reset = 1'b1;
    step  = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_during: tx=%b busy=%b required tx=1 busy=0", tx, busy);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b required 0", dropped); end
    tb0 = tx_low_cnt; bb0 = busy_cnt;
    repeat (60) @(negedge clock);
    checks++;
    if (tx_low_cnt - tb0 !== 0) begin
      errors++; $display("FAIL reset_no_line: tx low cycles %0d required 0", tx_low_cnt - tb0);
    end
    checks++;
    if (busy_cnt - bb0 !== 0) begin
      errors++; $display("FAIL reset_no_busy: busy cycles %0d required 0", busy_cnt - bb0);
    end
  endtask

  task automatic test_basic;
    logic [7:0] exp_b [21] = '{8'h30, 8'h35, 8'h20, 8'h30, 8'h31, 8'h43, 8'h20, 8'h52,
                               8'h30, 8'h33, 8'h3D, 8'h44, 8'h45, 8'h41, 8'h44, 8'h42,
                               8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    int bb0, bad_gap;
    fire_step(8'h05, 9'h01C, 5'd3, 32'hDEADBEEF);
    bb0 = busy_cnt;
    recv_line(4);
    checks++;
    if (timed_out !== 0) begin errors++; $display("FAIL basic_timeout: line not received"); end
    checks++;
    if (frame_err !== 0) begin errors++; $display("FAIL basic_framing: %0d bad start/stop bits, required 0", frame_err); end
    for (int i = 0; i < 21; i++) begin
      checks++;
      if (rx[i] !== exp_b[i]) begin
        errors++; $display("FAIL basic_char[%0d]: got %h required %h", i, rx[i], exp_b[i]);
      end
    end
    checks++;
    if (waits[0] !== 1) begin errors++; $display("FAIL basic_start_latency: start seen after %0d cycles, required 1", waits[0]); end
    bad_gap = 0;
    for (int i = 1; i < 21; i++) if (waits[i] !== CPB/2) bad_gap++;
    checks++;
    if (bad_gap !== 0) begin errors++; $display("FAIL basic_back_to_back: %0d characters with idle gap, required 0", bad_gap); end
    repeat (4) @(negedge clock);
    checks++;
    if (busy_cnt - bb0 !== 840) begin errors++; $display("FAIL basic_busy_len: %0d cycles required 840", busy_cnt - bb0); end
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL basic_end_idle: busy=%b tx=%b required 0 1", busy, tx); end
    checks++;
    if (dropped !== 1'b0) begin errors++; $display("FAIL basic_dropped: got %b required 0", dropped); end
  endtask

  task automatic test_drop_and_change;
    string s = "05 01C R03=DEADBEEF";
    int tb0;
    fire_step(8'h05, 9'h01C, 5'd3, 32'hDEADBEEF);
    fork
      recv_line(4);
      begin
        repeat (98) @(negedge clock);
        step = 1'b0;
        repeat (2) @(negedge clock);
        step = 1'b1;
        repeat (200) @(negedge clock);
        reg_data = 32'd0;
      end
    join
    checks++;
    if (timed_out !== 0 || frame_err !== 0) begin
      errors++; $display("FAIL drop_line_rx: timeout=%0d frame_err=%0d required 0 0", timed_out, frame_err);
    end
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (rx[i] !== s[i]) begin errors++; $display("FAIL drop_char[%0d]: got %h required %h", i, rx[i], s[i]); end
    end
    checks++;
    if (rx[19] !== 8'h0D || rx[20] !== 8'h0A) begin
      errors++; $display("FAIL drop_crlf: got %h %h required 0d 0a", rx[19], rx[20]);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (dropped !== 1'b1) begin errors++; $display("FAIL drop_flag: got %b required 1", dropped); end
    step = 1'b0;
    tb0 = tx_low_cnt;
    repeat (80) @(negedge clock);
    checks++;
    if (tx_low_cnt - tb0 !== 0) begin errors++; $display("FAIL drop_no_second_line: tx low %0d cycles required 0", tx_low_cnt - tb0); end
    checks++;
    if (dropped !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b required 1", dropped); end
  endtask

  task automatic test_rearm;
    string s = "06 1FF R1F=00000000";
    fire_step(8'h06, 9'h0AA, 5'd1, 32'h11111111);
    recv_line(4);
    step = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rearm_busy_last: got %b required 1", busy); end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rearm_busy_fell: got %b required 0", busy); end
    step_count = 8'h06; pc = 9'h1FF; reg_sel = 5'd31; reg_data = 32'd0;
    step = 1'b1;
    recv_line(4);
    checks++;
    if (timed_out !== 0 || waits[0] !== 1) begin
      errors++; $display("FAIL rearm_no_gap: timeout=%0d start after %0d cycles, required 0 1", timed_out, waits[0]);
    end
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (rx[i] !== s[i]) begin errors++; $display("FAIL rearm_char[%0d]: got %h required %h", i, rx[i], s[i]); end
    end
    checks++;
    if (rx[19] !== 8'h0D || rx[20] !== 8'h0A) begin
      errors++; $display("FAIL rearm_crlf: got %h %h required 0d 0a", rx[19], rx[20]);
    end
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset_midline;
    string s = "7A 0A5 R10=0123ABCD";
    fire_step(8'h33, 9'h044, 5'd2, 32'h55555555);
    repeat (301) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midreset_precond: busy=%b required 1", busy); end
    reset = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_async: tx=%b busy=%b required 1 0", tx, busy);
    end
    checks++;
    if (dropped !== 1'b0) begin errors++; $display("FAIL midreset_dropped: got %b required 0", dropped); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_after: tx=%b busy=%b required 1 0", tx, busy);
    end
    fire_step(8'h7A, 9'h0A5, 5'd16, 32'h0123ABCD);
    recv_line(4);
    checks++;
    if (timed_out !== 0 || frame_err !== 0) begin
      errors++; $display("FAIL midreset_line_rx: timeout=%0d frame_err=%0d required 0 0", timed_out, frame_err);
    end
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (rx[i] !== s[i]) begin errors++; $display("FAIL midreset_char[%0d]: got %h required %h", i, rx[i], s[i]); end
    end
    checks++;
    if (rx[19] !== 8'h0D || rx[20] !== 8'h0A) begin
      errors++; $display("FAIL midreset_crlf: got %h %h required 0d 0a", rx[19], rx[20]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_drop_and_change;
    test_rearm;
    test_reset_midline;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
